// File: rtl/rx_edge_bit_sampler.sv
// rx_edge_bit_sampler
// Oversampling edge/bit counter and 3-point majority sampler for a UART receiver.
// Counts Prescale oversamples per bit and 10 or 11 bits per frame. It votes the
// middle three oversamples of every bit and strobes the result downstream.
//
// Ports
//   CLK             in   1  receive clock at Prescale x baud
//   RST             in   1  synchronous active-high reset
//   enable          in   1  frame active, from the RX FSM
//   RX_IN           in   1  synchronised serial line
//   Prescale        in   6  oversampling ratio (8, 16, 32; anything else acts as 8)
//   PAR_EN          in   1  parity bit present in the frame
//   edge_cnt        out  6  oversample index within the current bit
//   bit_cnt         out  4  bit index within the frame (0 start, 1..8 data, 9/10 parity/stop)
//   sampled_bit     out  1  majority-voted bit value
//   sample_valid    out  1  one-cycle strobe: sampled_bit is new
//   deserializer_en out  1  one-cycle shift strobe, data bits only
//   frame_done      out  1  high on the final oversample of the last bit
module rx_edge_bit_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       RX_IN,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       deserializer_en,
  output logic       frame_done
);

  localparam logic [5:0] P_DEFAULT = 6'd8;

  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       sampled_q, sampled_d;
  logic       valid_q, valid_d;
  logic       deser_q, deser_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic [5:0] p_q, p_d;
  logic       par_q, par_d;
  logic       en_q;

  logic       first;
  logic [5:0] p_legal;
  logic [5:0] p_eff;
  logic       par_eff;
  logic [5:0] p_half;
  logic [3:0] bit_last;
  logic       edge_wrap;
  logic       frame_end;

  // Map illegal oversampling ratios onto the safe default.
  always_comb begin
    case (Prescale)
      6'd8, 6'd16, 6'd32: p_legal = Prescale;
      default:            p_legal = P_DEFAULT;
    endcase
  end

  // On the first enabled cycle the latched copies are not yet loaded, so the
  // live inputs are used directly; afterwards the frozen copies rule.
  assign first     = enable & ~en_q;
  assign p_eff     = first ? p_legal : p_q;
  assign par_eff   = first ? PAR_EN  : par_q;
  assign p_half    = p_eff >> 1;
  assign bit_last  = par_eff ? 4'd10 : 4'd9;
  assign edge_wrap = (edge_q == p_eff - 6'd1);
  assign frame_end = edge_wrap && (bit_q == bit_last);

  // NOTE: every signal written here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    edge_d    = '0;
    bit_d     = '0;
    valid_d   = 1'b0;
    deser_d   = 1'b0;
    sampled_d = sampled_q;
    s0_d      = 1'b0;
    s1_d      = 1'b0;
    p_d       = p_q;
    par_d     = par_q;

    if (enable) begin
      p_d   = p_eff;
      par_d = par_eff;
      s0_d  = s0_q;
      s1_d  = s1_q;

      if (edge_wrap) begin
        edge_d = '0;
        bit_d  = frame_end ? 4'd0 : bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 6'd1;
        bit_d  = bit_q;
      end

      if (edge_q == p_half - 6'd2) s0_d = RX_IN;
      if (edge_q == p_half - 6'd1) s1_d = RX_IN;

      // Third sample point: vote and strobe. The strobe is registered, so it
      // appears one clock later, tagged with the bit index of the sampled bit.
      if (edge_q == p_half) begin
        sampled_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
        valid_d   = 1'b1;
        deser_d   = (bit_q >= 4'd1) && (bit_q <= 4'd8);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_q    <= '0;
      bit_q     <= '0;
      sampled_q <= 1'b1;
      valid_q   <= 1'b0;
      deser_q   <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      p_q       <= P_DEFAULT;
      par_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      sampled_q <= sampled_d;
      valid_q   <= valid_d;
      deser_q   <= deser_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      p_q       <= p_d;
      par_q     <= par_d;
      en_q      <= enable;
    end
  end

  assign edge_cnt        = edge_q;
  assign bit_cnt         = bit_q;
  assign sampled_bit     = sampled_q;
  assign sample_valid    = valid_q;
  assign deserializer_en = deser_q;
  assign frame_done      = enable & ~RST & frame_end;

endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Self-checking bench for rx_edge_bit_sampler: a cycle-level behavioural model
// (frame position as a single cycle offset) compared on every negedge, plus
// hand-computed literal expectations per directed frame.
module tb_rx_edge_bit_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;
  logic       deserializer_en;
  logic       frame_done;

  rx_edge_bit_sampler dut (
    .CLK            (CLK),
    .RST            (RST),
    .enable         (enable),
    .RX_IN          (RX_IN),
    .Prescale       (Prescale),
    .PAR_EN         (PAR_EN),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .sampled_bit    (sampled_bit),
    .sample_valid   (sample_valid),
    .deserializer_en(deserializer_en),
    .frame_done     (frame_done)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int legal_p(input int p);
    return (p == 8 || p == 16 || p == 32) ? p : 8;
  endfunction

  // ---------------- behavioural model + observer ----------------
  int   m_P = 8, m_N = 10, m_t = 0;
  bit   m_act = 1'b0;
  logic m_sb = 1'b1, m_sv = 1'b0, m_de = 1'b0, m_r0 = 1'b0, m_r1 = 1'b0;

  int         tot_valid = 0, tot_deser = 0, done_at = -1, done_edge = -1, done_bit = -1;
  logic [7:0] deser_sh = 8'h00;

  always @(negedge CLK) begin
    int eP, eN, e, b;
    eP = (enable && !m_act) ? legal_p(int'(Prescale)) : m_P;
    eN = (enable && !m_act) ? (PAR_EN ? 11 : 10) : m_N;

    if (chk_en) begin
      check("edge_cnt",        edge_cnt,        m_t % eP);
      check("bit_cnt",         bit_cnt,         m_t / eP);
      check("sampled_bit",     sampled_bit,     m_sb);
      check("sample_valid",    sample_valid,    m_sv);
      check("deserializer_en", deserializer_en, m_de);
      check("frame_done",      frame_done,      (!RST && enable && m_t == eP * eN - 1) ? 1 : 0);
    end

    if (sample_valid) tot_valid++;
    if (deserializer_en) begin
      tot_deser++;
      deser_sh = {sampled_bit, deser_sh[7:1]};
    end
    if (frame_done) begin
      done_at   = cyc;
      done_edge = int'(edge_cnt);
      done_bit  = int'(bit_cnt);
    end

    // Advance the model across the coming rising edge (inputs are stable now).
    if (RST) begin
      m_act = 1'b0; m_t = 0; m_sb = 1'b1; m_sv = 1'b0; m_de = 1'b0;
      m_r0 = 1'b0; m_r1 = 1'b0; m_P = 8; m_N = 10;
    end else if (!enable) begin
      m_act = 1'b0; m_t = 0; m_sv = 1'b0; m_de = 1'b0;
    end else begin
      m_P = eP; m_N = eN; m_act = 1'b1;
      e = m_t % m_P;
      b = m_t / m_P;
      m_sv = 1'b0; m_de = 1'b0;
      if (e == m_P / 2 - 2) m_r0 = RX_IN;
      if (e == m_P / 2 - 1) m_r1 = RX_IN;
      if (e == m_P / 2) begin
        m_sb = ((int'(m_r0) + int'(m_r1) + int'(RX_IN)) >= 2);
        m_sv = 1'b1;
        m_de = (b >= 1 && b <= 8);
      end
      m_t = (m_t + 1) % (m_P * m_N);
    end
  end

  // ---------------- stimulus ----------------
  int s_cyc, s_valid, s_deser;

  function automatic logic frame_bit(input logic [7:0] d, input bit par, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && par) return ^d;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      RST = 1'b0; enable = 1'b0; RX_IN = 1'b1;
    end
  endtask

  // Drives ncyc cycles of a frame (ncyc < 0: whole frame). Bit gbit has RX_IN
  // inverted on every oversample whose bit is set in gmask. Prescale/PAR_EN are
  // scrambled after the first cycle to prove they are held internally.
  task automatic run_frame(input logic [5:0] pres, input bit par, input logic [7:0] data,
                           input int gbit, input logic [31:0] gmask, input int ncyc);
    int p, n, b, e;
    p = legal_p(int'(pres));
    n = par ? 11 : 10;
    if (ncyc < 0) ncyc = p * n;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge CLK); #1;
      if (c == 0) begin
        s_cyc = cyc; s_valid = tot_valid; s_deser = tot_deser;
        Prescale = pres; PAR_EN = par;
      end else begin
        Prescale = ~pres; PAR_EN = ~par;
      end
      RST = 1'b0; enable = 1'b1;
      b = c / p; e = c % p;
      RX_IN = frame_bit(data, par, b) ^ ((b == gbit) && gmask[e]);
    end
  endtask

  initial begin
    RST = 1'b1; enable = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk_en = 1'b1;
    @(negedge CLK);
    check("rst_edge_cnt",     edge_cnt,        0);
    check("rst_bit_cnt",      bit_cnt,         0);
    check("rst_sampled_bit",  sampled_bit,     1);
    check("rst_sample_valid", sample_valid,    0);
    check("rst_deser_en",     deserializer_en, 0);
    check("rst_frame_done",   frame_done,      0);
    idle(2);

    // P=8, no parity, 0xA5
    run_frame(6'd8, 1'b0, 8'hA5, -1, 32'h0, -1);
    idle(2);
    check("a5_byte",       deser_sh, 8'hA5);
    check("a5_deser_cnt",  tot_deser - s_deser, 8);
    check("a5_valid_cnt",  tot_valid - s_valid, 10);
    check("a5_done_cycle", done_at - s_cyc + 1, 80);
    check("a5_done_edge",  done_edge, 7);
    check("a5_done_bit",   done_bit, 9);

    // P=16, parity, 0x3C
    run_frame(6'd16, 1'b1, 8'h3C, -1, 32'h0, -1);
    idle(2);
    check("3c_byte",       deser_sh, 8'h3C);
    check("3c_valid_cnt",  tot_valid - s_valid, 11);
    check("3c_deser_cnt",  tot_deser - s_deser, 8);
    check("3c_done_cycle", done_at - s_cyc + 1, 176);
    check("3c_done_edge",  done_edge, 15);
    check("3c_done_bit",   done_bit, 10);

    // P=32, single glitch at edge 15 of data bit 0: outvoted
    run_frame(6'd32, 1'b0, 8'hFF, 1, 32'h0000_8000, -1);
    idle(2);
    check("glitch1_byte", deser_sh, 8'hFF);
    // Glitch on two sample points (14 and 15): flips data bit 0
    run_frame(6'd32, 1'b0, 8'hFF, 1, 32'h0000_C000, -1);
    idle(2);
    check("glitch2_byte", deser_sh, 8'hFE);

    // Illegal Prescale=13 behaves as 8
    run_frame(6'd13, 1'b0, 8'h96, -1, 32'h0, -1);
    idle(2);
    check("p13_byte",       deser_sh, 8'h96);
    check("p13_done_cycle", done_at - s_cyc + 1, 80);
    check("p13_done_edge",  done_edge, 7);

    // Abort: enable low on the cycle bit_cnt=4, edge_cnt=4 (P=8)
    run_frame(6'd8, 1'b0, 8'hA5, -1, 32'h0, 36);
    @(posedge CLK); #1 enable = 1'b0; RX_IN = 1'b1;
    @(negedge CLK);
    check("abort_hold_bit", bit_cnt, 4);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_no_valid",  sample_valid, 0);
    check("abort_edge_zero", edge_cnt, 0);
    check("abort_bit_zero",  bit_cnt, 0);
    check("abort_valid_cnt", tot_valid - s_valid, 4);
    idle(2);

    // Reset mid-frame at bit_cnt=5 (P=16, data 0x00 so sampled_bit is 0 before)
    run_frame(6'd16, 1'b0, 8'h00, -1, 32'h0, 83);
    @(negedge CLK);
    check("pre_rst_sampled", sampled_bit, 0);
    @(posedge CLK); #1 RST = 1'b1; enable = 1'b1; RX_IN = 1'b1;
    @(posedge CLK); #1 RST = 1'b0; enable = 1'b0;
    @(negedge CLK);
    check("midrst_edge_cnt", edge_cnt, 0);
    check("midrst_bit_cnt",  bit_cnt, 0);
    check("midrst_sampled",  sampled_bit, 1);
    check("midrst_valid",    sample_valid, 0);
    idle(1);
    run_frame(6'd8, 1'b0, 8'h5A, -1, 32'h0, -1);
    idle(2);
    check("post_rst_byte",       deser_sh, 8'h5A);
    check("post_rst_done_cycle", done_at - s_cyc + 1, 80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
